// File: rtl/loadable_sync_down_counter_4b.sv
// Loadable synchronous down counter with a two-state run/idle FSM,
// one-shot or auto-reload operation, and a registered done pulse.
module loadable_sync_down_counter_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] I,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           st, st_nx;
  logic [WIDTH-1:0] r, r_nx;
  logic [WIDTH-1:0] q_nx;
  logic             done_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st   <= IDLE;
      q    <= '0;
      r    <= '0;
      done <= 1'b0;
    end else begin
      st   <= st_nx;
      q    <= q_nx;
      r    <= r_nx;
      done <= done_nx;
    end
  end

  always_comb begin
    st_nx   = st;
    q_nx    = q;
    r_nx    = r;
    done_nx = 1'b0;
    if (load) begin
      q_nx  = I;
      r_nx  = I;
      st_nx = (I != '0) ? RUN : IDLE;
    end else if (en && st == RUN) begin
      unique case (1'b1)
        (q > ONE): q_nx = q - ONE;
        (q == ONE): begin
          q_nx    = '0;
          done_nx = 1'b1;
          if (!auto_reload) st_nx = IDLE;
        end
        default: begin
          // q==0 in RUN only happens one edge after an auto-reload wrap
          if (auto_reload) q_nx = r;
          else st_nx = IDLE;
        end
      endcase
    end
  end

  assign busy = (st == RUN);
  assign zero = (q == '0);

endmodule

// File: tb/tb_loadable_sync_down_counter_4b.sv
// Directed bench with a cycle-level reference model and per-cycle compare.
// Literal pins anchor the model at key points of each scenario.
module tb_loadable_sync_down_counter_4b;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       load = 1'b0;
  logic [3:0] I = 4'd0;
  logic       en = 1'b0;
  logic       auto_reload = 1'b0;
  logic [3:0] q;
  logic       busy, done, zero;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  bit prev_done = 1'b0;
  int done_cnt = 0;

  int mq = 0;
  int mr = 0;
  bit mrun = 1'b0;
  bit mdone = 1'b0;

  loadable_sync_down_counter_4b #(.WIDTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .I(I),
    .en(en),
    .auto_reload(auto_reload),
    .q(q),
    .busy(busy),
    .done(done),
    .zero(zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq = 0; mr = 0; mrun = 0; mdone = 0;
    end else if (load) begin
      mq = int'(I); mr = int'(I); mrun = (I != 0); mdone = 0;
    end else if (mrun && en) begin
      if (mq == 0) begin
        if (auto_reload) mq = mr;
        else mrun = 0;
        mdone = 0;
      end else begin
        mq = mq - 1;
        mdone = (mq == 0);
        if (mq == 0 && !auto_reload) mrun = 0;
      end
    end else begin
      mdone = 0;
    end
  end

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_q", int'(q), mq);
      chk("model_busy", int'(busy), int'(mrun));
      chk("model_done", int'(done), int'(mdone));
      chk("model_zero", int'(zero), int'(mq == 0));
      chk("done_not_twice", int'(done && prev_done), 0);
      prev_done = done;
      if (done) done_cnt++;
    end
  end

  task automatic drive(bit l, int i, bit e, bit a);
    load = l;
    I = 4'(i);
    en = e;
    auto_reload = a;
    @(negedge clk);
  endtask

  initial begin
    #1 rst = 1'b0;
    chk_en = 1'b1;
    // reset then idle
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    chk("rst_q", int'(q), 0);
    chk("rst_zero", int'(zero), 1);
    rst = 1'b1;
    repeat (5) drive(0, 0, 1, 0);
    chk("idle_q", int'(q), 0);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done_cnt", done_cnt, 0);

    // one-shot from 6
    drive(1, 6, 1, 0);
    chk("os_load_q", int'(q), 6);
    chk("os_load_busy", int'(busy), 1);
    repeat (5) drive(0, 0, 1, 0);
    chk("os_q1", int'(q), 1);
    drive(0, 0, 1, 0);
    chk("os_q0", int'(q), 0);
    chk("os_done", int'(done), 1);
    chk("os_busy_drop", int'(busy), 0);
    drive(0, 0, 1, 0);
    chk("os_hold_q", int'(q), 0);
    chk("os_done_once", int'(done), 0);

    // auto-reload from 3
    done_cnt = 0;
    drive(1, 3, 1, 1);
    repeat (8) drive(0, 0, 1, 1);
    chk("ar_q", int'(q), 3);
    chk("ar_busy", int'(busy), 1);
    chk("ar_done_cnt", done_cnt, 2);
    drive(0, 0, 1, 1);
    chk("ar_q2", int'(q), 2);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("ar_stop_q", int'(q), 0);
    chk("ar_stop_done", int'(done), 1);
    chk("ar_stop_busy", int'(busy), 0);
    drive(0, 0, 1, 1);
    chk("ar_idle_q", int'(q), 0);

    // enable gaps and load override
    drive(1, 5, 1, 0);
    drive(0, 0, 0, 0);
    chk("gap_hold", int'(q), 5);
    drive(0, 0, 1, 0);
    drive(0, 0, 0, 0);
    chk("gap_q4", int'(q), 4);
    repeat (3) drive(0, 0, 1, 0);
    chk("gap_q1", int'(q), 1);
    drive(1, 9, 1, 0);
    chk("ovr_q", int'(q), 9);
    chk("ovr_done", int'(done), 0);
    chk("ovr_busy", int'(busy), 1);

    // zero load
    drive(1, 0, 1, 0);
    chk("z_q", int'(q), 0);
    chk("z_busy", int'(busy), 0);
    chk("z_done", int'(done), 0);
    drive(0, 0, 1, 1);
    chk("z_hold", int'(q), 0);

    // async reset mid-count
    drive(1, 12, 1, 0);
    repeat (5) drive(0, 0, 1, 0);
    chk("ar7_q", int'(q), 7);
    done_cnt = 0;
    #2 rst = 1'b0;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_done", int'(done), 0);
    chk("arst_zero", int'(zero), 1);
    drive(0, 0, 1, 1);
    rst = 1'b1;
    repeat (3) drive(0, 0, 1, 1);
    chk("post_q", int'(q), 0);
    chk("post_busy", int'(busy), 0);
    chk("post_done_cnt", done_cnt, 0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
